mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single unified instruction/data memory port between the multicycle core and the program loader (UART/debug boot path).
- Issues at most one transaction per cycle, using round-robin with a bounded burst length.
- Routes read data back to the winning requester one cycle after issue.
- Sits between CORE's memory interface (core_* ports) and the memory macro (mem_* ports).
- The core holds its FSM while core_req_i=1 and core_gnt_o=0.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (core, loader) and memory-macro signals around mem_port_arbiter.
// slave is the arbiter's view; master is the environment driving requests and memory data.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  core_req_i;
    logic                  core_we_i;
    logic [ADDR_WIDTH-1:0] core_addr_i;
    logic [DATA_WIDTH-1:0] core_wdata_i;
    logic                  core_gnt_o;
    logic                  core_rvalid_o;
    logic [DATA_WIDTH-1:0] core_rdata_o;

    logic                  ldr_req_i;
    logic                  ldr_we_i;
    logic [ADDR_WIDTH-1:0] ldr_addr_i;
    logic [DATA_WIDTH-1:0] ldr_wdata_i;
    logic                  ldr_gnt_o;
    logic                  ldr_rvalid_o;
    logic [DATA_WIDTH-1:0] ldr_rdata_o;

    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
        input  ldr_req_i, ldr_we_i, ldr_addr_i, ldr_wdata_i,
        input  mem_rdata_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o,
        output ldr_gnt_o, ldr_rvalid_o, ldr_rdata_o,
        output mem_addr_o, mem_wdata_o, mem_we_o
    );

    modport master (
        output core_req_i, core_we_i, core_addr_i, core_wdata_i,
        output ldr_req_i, ldr_we_i, ldr_addr_i, ldr_wdata_i,
        output mem_rdata_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o,
        input  ldr_gnt_o, ldr_rvalid_o, ldr_rdata_o,
        input  mem_addr_o, mem_wdata_o, mem_we_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one memory port between core and loader.
// Grants are combinational; read data returns to the issuing requester one cycle later.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);
    localparam logic [CntW-1:0] OneCnt = CntW'(1);

    typedef enum logic [1:0] {StIdle, StOwnCore, StOwnLdr} state_e;
    typedef enum logic {OwnerCore, OwnerLdr} owner_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
    owner_e          last_owner_q, last_owner_d;
    logic            core_rvalid_q, core_rvalid_d;
    logic            ldr_rvalid_q, ldr_rvalid_d;

    logic            gnt_core, gnt_ldr;
    logic            core_req, ldr_req;
    logic            burst_open;
    logic [CntW-1:0] burst_inc;

    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;
    logic                  mem_we_d;
    logic                  core_rvalid_out, ldr_rvalid_out;

    assign core_req   = bus.core_req_i;
    assign ldr_req    = bus.ldr_req_i;
    assign burst_open = (burst_cnt_q < MaxCnt);
    assign burst_inc  = burst_open ? (burst_cnt_q + OneCnt) : MaxCnt;

    always_comb begin
        gnt_core = 1'b0;
        gnt_ldr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // On a tie, whoever was served last yields.
                if (core_req && ldr_req) begin
                    if (last_owner_q == OwnerLdr) gnt_core = 1'b1;
                    else                          gnt_ldr  = 1'b1;
                end else if (core_req) begin
                    gnt_core = 1'b1;
                end else if (ldr_req) begin
                    gnt_ldr = 1'b1;
                end
            end
            StOwnCore: begin
                if (core_req && (!ldr_req || burst_open)) gnt_core = 1'b1;
                else if (ldr_req)                         gnt_ldr  = 1'b1;
            end
            StOwnLdr: begin
                if (ldr_req && (!core_req || burst_open)) gnt_ldr  = 1'b1;
                else if (core_req)                        gnt_core = 1'b1;
            end
            default: begin
                gnt_core = 1'b0;
                gnt_ldr  = 1'b0;
            end
        endcase
        if (reset) begin
            gnt_core = 1'b0;
            gnt_ldr  = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        last_owner_d = last_owner_q;
        if (gnt_core) begin
            state_d      = StOwnCore;
            last_owner_d = OwnerCore;
            burst_cnt_d  = (state_q == StOwnCore) ? burst_inc : OneCnt;
        end else if (gnt_ldr) begin
            state_d      = StOwnLdr;
            last_owner_d = OwnerLdr;
            burst_cnt_d  = (state_q == StOwnLdr) ? burst_inc : OneCnt;
        end else begin
            state_d     = StIdle;
            burst_cnt_d = '0;
        end
        core_rvalid_d = gnt_core & ~bus.core_we_i;
        ldr_rvalid_d  = gnt_ldr & ~bus.ldr_we_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            burst_cnt_q   <= '0;
            last_owner_q  <= OwnerLdr;
            core_rvalid_q <= 1'b0;
            ldr_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            last_owner_q  <= last_owner_d;
            core_rvalid_q <= core_rvalid_d;
            ldr_rvalid_q  <= ldr_rvalid_d;
        end
    end

    always_comb begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        if (gnt_core) begin
            mem_addr_d  = bus.core_addr_i;
            mem_wdata_d = bus.core_wdata_i;
            mem_we_d    = bus.core_we_i;
        end else if (gnt_ldr) begin
            mem_addr_d  = bus.ldr_addr_i;
            mem_wdata_d = bus.ldr_wdata_i;
            mem_we_d    = bus.ldr_we_i;
        end
    end

    // A read issued just before reset must not surface while reset is held.
    assign core_rvalid_out = core_rvalid_q & ~reset;
    assign ldr_rvalid_out  = ldr_rvalid_q & ~reset;

    assign bus.core_gnt_o    = gnt_core;
    assign bus.ldr_gnt_o     = gnt_ldr;
    assign bus.mem_addr_o    = mem_addr_d;
    assign bus.mem_wdata_o   = mem_wdata_d;
    assign bus.mem_we_o      = mem_we_d;
    assign bus.core_rvalid_o = core_rvalid_out;
    assign bus.ldr_rvalid_o  = ldr_rvalid_out;
    assign bus.core_rdata_o  = core_rvalid_out ? bus.mem_rdata_i : '0;
    assign bus.ldr_rdata_o   = ldr_rvalid_out ? bus.mem_rdata_i : '0;

    a_gnt_exclusive: assert property (@(posedge clk) !(gnt_core && gnt_ldr));
    a_we_needs_gnt:  assert property (@(posedge clk) mem_we_d |-> (gnt_core || gnt_ldr));
    a_burst_bound:   assert property (@(posedge clk) disable iff (reset) burst_cnt_q <= MaxCnt);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter against a fairness-rule reference model.
module tb_mem_port_arbiter;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int          MAXB = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int          who;   // 0 none, 1 core, 2 loader
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iss_t;

    typedef struct {
        int          who;
        logic [31:0] data;
        int          due;
    } rd_t;

    iss_t iss_q[$];
    rd_t  rd_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_on = 1'b0;

    // Reference model: who was served last and how long the current uninterrupted run is.
    int last_owner = 2;
    int run_owner  = 0;
    int run_len    = 0;

    bit          c_req = 1'b0, l_req = 1'b0;
    logic        c_we = 1'b0, l_we = 1'b0;
    logic [31:0] c_addr = '0, l_addr = '0, c_wd = '0, l_wd = '0;

    function automatic logic [31:0] rd_func(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
    endfunction

    always @(posedge clk) bus.mem_rdata_i <= rd_func(bus.mem_addr_o);

    task automatic chk(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: %s", name, cyc, detail);
        end
    endtask

    function automatic int pick(input bit cr, input bit lr);
        if (!cr && !lr) return 0;
        if (cr && !lr) return 1;
        if (lr && !cr) return 2;
        if (run_len == 0) return (last_owner == 1) ? 2 : 1;
        if (run_len < MAXB) return run_owner;
        return 3 - run_owner;
    endfunction

    task automatic new_core(input bit we);
        c_req = 1'b1; c_we = we; c_addr = $urandom & 32'h0000_fffc; c_wd = $urandom;
    endtask

    task automatic new_ldr(input bit we);
        l_req = 1'b1; l_we = we; l_addr = $urandom & 32'h0000_fffc; l_wd = $urandom;
    endtask

    task automatic cycle(input bit rst);
        iss_t e;
        rd_t  r;
        int   g;
        @(posedge clk);
        #1;
        cyc++;
        reset = rst;
        bus.core_req_i   = c_req;
        bus.core_we_i    = c_req ? c_we : 1'($urandom);
        bus.core_addr_i  = c_req ? c_addr : $urandom;
        bus.core_wdata_i = c_req ? c_wd : $urandom;
        bus.ldr_req_i    = l_req;
        bus.ldr_we_i     = l_req ? l_we : 1'($urandom);
        bus.ldr_addr_i   = l_req ? l_addr : $urandom;
        bus.ldr_wdata_i  = l_req ? l_wd : $urandom;
        g = 0;
        if (rst) begin
            while (rd_q.size() > 0 && rd_q[$].due == cyc) void'(rd_q.pop_back());
            last_owner = 2; run_len = 0; run_owner = 0;
        end else begin
            g = pick(c_req, l_req);
            if (g == 0) begin
                run_len = 0;
            end else begin
                if (run_len > 0 && g == run_owner) run_len = (run_len < MAXB) ? run_len + 1 : MAXB;
                else run_len = 1;
                run_owner = g; last_owner = g;
            end
        end
        e.who = g; e.we = 1'b0; e.addr = '0; e.wdata = '0;
        if (g == 1) begin
            e.we = c_we; e.addr = c_addr; e.wdata = c_wd; c_req = 1'b0;
        end else if (g == 2) begin
            e.we = l_we; e.addr = l_addr; e.wdata = l_wd; l_req = 1'b0;
        end
        if (g != 0 && !e.we) begin
            r.who = g; r.data = rd_func(e.addr); r.due = cyc + 1;
            rd_q.push_back(r);
        end
        iss_q.push_back(e);
        mon_on = 1'b1;
    endtask

    // Monitor: compares the bus every cycle against what the stimulus side predicted.
    initial begin
        iss_t        e;
        rd_t         r;
        bit          ev_c, ev_l;
        logic [31:0] exp_cd, exp_ld;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (iss_q.size() == 0) begin
                    chk(1'b0, "issue_queue", "no expectation queued");
                end else begin
                    e = iss_q.pop_front();
                    chk(bus.core_gnt_o == (e.who == 1) && bus.ldr_gnt_o == (e.who == 2) &&
                        bus.mem_we_o == e.we && bus.mem_addr_o == e.addr &&
                        bus.mem_wdata_o == e.wdata, "issue",
                        $sformatf("got gnt c=%0b l=%0b we=%0b addr=%h wd=%h, want who=%0d we=%0b addr=%h wd=%h",
                                  bus.core_gnt_o, bus.ldr_gnt_o, bus.mem_we_o, bus.mem_addr_o,
                                  bus.mem_wdata_o, e.who, e.we, e.addr, e.wdata));
                end
                chk(!(bus.core_gnt_o && bus.ldr_gnt_o), "gnt_exclusive",
                    $sformatf("got both grants c=%0b l=%0b, want at most one",
                              bus.core_gnt_o, bus.ldr_gnt_o));
                ev_c = 1'b0; ev_l = 1'b0; exp_cd = '0; exp_ld = '0;
                if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                    r = rd_q.pop_front();
                    if (r.who == 1) begin ev_c = 1'b1; exp_cd = r.data; end
                    else begin ev_l = 1'b1; exp_ld = r.data; end
                end
                chk(bus.core_rvalid_o == ev_c && bus.core_rdata_o == exp_cd, "core_read_return",
                    $sformatf("got rvalid=%0b rdata=%h, want rvalid=%0b rdata=%h",
                              bus.core_rvalid_o, bus.core_rdata_o, ev_c, exp_cd));
                chk(bus.ldr_rvalid_o == ev_l && bus.ldr_rdata_o == exp_ld, "ldr_read_return",
                    $sformatf("got rvalid=%0b rdata=%h, want rvalid=%0b rdata=%h",
                              bus.ldr_rvalid_o, bus.ldr_rdata_o, ev_l, exp_ld));
            end
        end
    end

    initial begin
        bus.core_req_i = 1'b0; bus.core_we_i = 1'b0; bus.core_addr_i = '0; bus.core_wdata_i = '0;
        bus.ldr_req_i = 1'b0; bus.ldr_we_i = 1'b0; bus.ldr_addr_i = '0; bus.ldr_wdata_i = '0;
        for (int i = 0; i < 3; i++) cycle(1'b1);

        // Single core read of 0x40, then a loader write.
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0040; c_wd = 32'h0;
        cycle(1'b0);
        cycle(1'b0);
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0000_0100; l_wd = 32'hDEAD_BEEF;
        cycle(1'b0);
        cycle(1'b0);

        // Both requesters saturating with reads straight out of reset.
        cycle(1'b1);
        for (int i = 0; i < 40; i++) begin
            if (!c_req) new_core(1'b0);
            if (!l_req) new_ldr(1'b0);
            cycle(1'b0);
        end
        c_req = 1'b0; l_req = 1'b0;
        for (int i = 0; i < 10; i++) cycle(1'b0);

        // Core streaming, loader asks once at cycle 3 of the stream.
        cycle(1'b1);
        for (int i = 0; i < 15; i++) begin
            if (!c_req) new_core(1'b0);
            if (i == 3) new_ldr(1'b0);
            cycle(1'b0);
        end
        c_req = 1'b0; l_req = 1'b0;
        cycle(1'b0);

        // Read issued, then reset lands on the return cycle.
        new_core(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b1);
        new_ldr(1'b0);
        cycle(1'b0);
        cycle(1'b0);

        for (int i = 0; i < 3000; i++) begin
            if (!c_req && $urandom_range(3) != 0) new_core($urandom_range(3) == 0);
            else if (c_req && $urandom_range(15) == 0) c_req = 1'b0;
            if (!l_req && $urandom_range(2) == 0) new_ldr($urandom_range(2) == 0);
            else if (l_req && $urandom_range(15) == 0) l_req = 1'b0;
            cycle($urandom_range(199) == 0);
        end
        c_req = 1'b0; l_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0);

        @(negedge clk);
        #1;
        chk(rd_q.size() == 0 && iss_q.size() == 0, "drain",
            $sformatf("got %0d reads and %0d issues outstanding, want 0 and 0",
                      rd_q.size(), iss_q.size()));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
